// File: rtl/player_choice_capture_pkg.sv
// Shared definitions for the player choice capture path.
//  - Choice codes (one-hot): cat 001, dog 010, chicken 100.
//  - FSM state type for the capture sequencer.
//  - Helpers: choice validity check, waiting-player decode of a state.
package player_choice_capture_pkg;

  localparam int unsigned CHOICE_W_DEF = 3;

  localparam logic [CHOICE_W_DEF-1:0] CHOICE_CAT     = 3'b001;
  localparam logic [CHOICE_W_DEF-1:0] CHOICE_DOG     = 3'b010;
  localparam logic [CHOICE_W_DEF-1:0] CHOICE_CHICKEN = 3'b100;

  typedef enum logic [1:0] {
    WAIT_P1,
    WAIT_P2,
    HOLD
  } state_t;

  // Only the three animal codes are legal; 000 and multi-hot values are not.
  function automatic logic is_valid_choice(input logic [CHOICE_W_DEF-1:0] code);
    return (code == CHOICE_CAT) || (code == CHOICE_DOG) || (code == CHOICE_CHICKEN);
  endfunction

  // 01 = awaiting P1, 10 = awaiting P2, 00 = holding the captured pair.
  function automatic logic [1:0] waiting_code(input state_t s);
    case (s)
      WAIT_P1: return 2'b01;
      WAIT_P2: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/player_choice_capture_key_debounce.sv
// Key conditioner for an active-low push button.
//  - 2-flop synchronizer on the raw key.
//  - Debounced level changes only after the synced key has differed from it
//    for DEBOUNCE_CYCLES consecutive cycles; any shorter glitch restarts.
//  - press: registered 1-cycle pulse on the debounced released->pressed edge.
// Ports:
//  clk    in   system clock
//  rst    in   asynchronous active-high reset (level = released)
//  key_n  in   raw key, active-low, asynchronous, bouncy
//  press  out  1-cycle pulse per debounced press
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_meta;
  logic             key_sync;
  logic             level_n;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
      level_n  <= 1'b1;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      key_meta <= key_n;
      key_sync <= key_meta;
      press    <= 1'b0;
      if (key_sync == level_n) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Level flips on the DEBOUNCE_CYCLES-th differing cycle; only the
        // falling (pressed) direction produces a pulse.
        level_n <= key_sync;
        cnt     <= '0;
        press   <= ~key_sync;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/player_choice_capture.sv
// Player choice capture: two players in turn enter a one-hot choice on the
// shared switch bank and confirm with one debounced key. Both choices are
// validated, latched and then held as a stable pair until round_done.
// Ports:
//  clk            in   system clock
//  stateReset     in   asynchronous active-high reset
//  sw_choice      in   raw switch choice (asynchronous)
//  confirm_n      in   raw confirm key, active-low, bouncy
//  round_done     in   1-cycle pulse: round shown, start a new round
//  p1Choice       out  latched player-1 choice, 000 when not captured
//  p2Choice       out  latched player-2 choice, 000 when not captured
//  choicesValid   out  both choices captured and stable
//  waitingPlayer  out  01 awaiting P1, 10 awaiting P2, 00 holding pair
//  invalidFlag    out  1-cycle pulse: confirm with a non-one-hot switch value
module player_choice_capture
  import player_choice_capture_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CHOICE_W        = 3
) (
  input  logic                clk,
  input  logic                stateReset,
  input  logic [CHOICE_W-1:0] sw_choice,
  input  logic                confirm_n,
  input  logic                round_done,
  output logic [CHOICE_W-1:0] p1Choice,
  output logic [CHOICE_W-1:0] p2Choice,
  output logic                choicesValid,
  output logic [1:0]          waitingPlayer,
  output logic                invalidFlag
);

  logic                press;
  logic                sw_valid;
  logic [CHOICE_W-1:0] sw_meta;
  logic [CHOICE_W-1:0] sw_sync;
  state_t              state;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_confirm (
    .clk   (clk),
    .rst   (stateReset),
    .key_n (confirm_n),
    .press (press)
  );

  always_ff @(posedge clk or posedge stateReset) begin
    if (stateReset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_choice;
      sw_sync <= sw_meta;
    end
  end

  if (CHOICE_W == CHOICE_W_DEF) begin : g_codes
    assign sw_valid = is_valid_choice(sw_sync);
  end else begin : g_onehot
    assign sw_valid = $onehot(sw_sync);
  end

  // waitingPlayer is registered alongside the state so it always equals the
  // decode of the state register without a combinational output path.
  always_ff @(posedge clk or posedge stateReset) begin
    if (stateReset) begin
      state         <= WAIT_P1;
      p1Choice      <= '0;
      p2Choice      <= '0;
      choicesValid  <= 1'b0;
      waitingPlayer <= waiting_code(WAIT_P1);
      invalidFlag   <= 1'b0;
    end else begin
      invalidFlag <= 1'b0;
      case (state)
        WAIT_P1: begin
          if (press) begin
            if (sw_valid) begin
              p1Choice      <= sw_sync;
              state         <= WAIT_P2;
              waitingPlayer <= waiting_code(WAIT_P2);
            end else begin
              invalidFlag <= 1'b1;
            end
          end
        end
        WAIT_P2: begin
          if (press) begin
            if (sw_valid) begin
              p2Choice      <= sw_sync;
              choicesValid  <= 1'b1;
              state         <= HOLD;
              waitingPlayer <= waiting_code(HOLD);
            end else begin
              invalidFlag <= 1'b1;
            end
          end
        end
        HOLD: begin
          // Presses are dropped here, so a press coinciding with round_done
          // never reaches WAIT_P1.
          if (round_done) begin
            p1Choice      <= '0;
            p2Choice      <= '0;
            choicesValid  <= 1'b0;
            state         <= WAIT_P1;
            waitingPlayer <= waiting_code(WAIT_P1);
          end
        end
        default: begin
          p1Choice      <= '0;
          p2Choice      <= '0;
          choicesValid  <= 1'b0;
          state         <= WAIT_P1;
          waitingPlayer <= waiting_code(WAIT_P1);
        end
      endcase
    end
  end

endmodule
